// File: rtl/pswallow_pkg.sv
// Shared definitions for the pulse-swallow controller: FSM states and
// divider modulus codes driven back to the 2/3 prescaler.
package pswallow_pkg;

    typedef enum logic {
        SWALLOW = 1'b0,
        COUNT   = 1'b1
    } state_t;

    localparam logic [3:0] MC_DIV2 = 4'd1;
    localparam logic [3:0] MC_DIV3 = 4'd2;

    // Modulus code the prescaler must use while the FSM sits in a given state.
    function automatic logic [3:0] mc_for(input state_t st);
        return (st == SWALLOW) ? MC_DIV3 : MC_DIV2;
    endfunction

endpackage

// File: rtl/pulse_swallow_cfg_reg.sv
// Configuration shadow register for the pulse-swallow controller.
// Accepts (P, S) through a valid/ready handshake, holds it pending until the
// controller consumes it at a period wrap, then reopens the handshake.
// Optional macro PSWALLOW_CFG_CHECK_EN: offers with P < 2 or S > P complete
// the handshake but are dropped, and raise a sticky cfg_err.
module pulse_swallow_cfg_reg
    import pswallow_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_p,
    input  logic [WIDTH-1:0] cfg_s,
    input  logic             wrap,
    output logic             cfg_ready,
    output logic             pending,
    output logic [WIDTH-1:0] shadow_p,
    output logic [WIDTH-1:0] shadow_s,
    output logic             cfg_err
);

    logic accept;
    logic cfg_legal;
    logic capture;
    logic pending_nxt;

    assign accept = cfg_valid && cfg_ready;

`ifdef PSWALLOW_CFG_CHECK_EN
    assign cfg_legal = (cfg_p >= WIDTH'(2)) && (cfg_s <= cfg_p);
`else
    assign cfg_legal = 1'b1;
`endif

    assign capture = accept && cfg_legal;

    // Pending is consumed by a wrap that was already pending before the edge;
    // a capture on a wrap edge therefore waits for the following wrap.
    always_comb begin
        pending_nxt = pending;
        if (wrap && pending) begin
            pending_nxt = 1'b0;
        end else if (capture) begin
            pending_nxt = 1'b1;
        end
    end

    // Pending flag and ready output; ready is simply the inverse of pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending   <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            pending   <= pending_nxt;
            cfg_ready <= !pending_nxt;
        end
    end

    // Shadow data only changes on a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow_p <= cfg_p;
            shadow_s <= cfg_s;
        end
    end

`ifdef PSWALLOW_CFG_CHECK_EN
    // Sticky error: any accepted-but-illegal offer latches until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else if (accept && !cfg_legal) begin
            cfg_err <= 1'b1;
        end
    end
`else
    assign cfg_err = 1'b0;
`endif

endmodule

// File: rtl/pulse_swallow_ctrl.sv
// Dual-modulus (pulse-swallow) controller clocked by the 2/3 prescaler output.
// Each output period spans P prescaler periods; the first S of them run the
// prescaler in divide-by-3, the rest in divide-by-2, for N = 2P + S input
// clocks. New (P, S) settings are taken through pulse_swallow_cfg_reg and
// applied only at a period wrap, so the output never glitches.
// Optional macro PSWALLOW_CFG_CHECK_EN enables the legality check / cfg_err.
module pulse_swallow_ctrl
    import pswallow_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int P_RST = 2,
    parameter int S_RST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [WIDTH-1:0] cfg_p,
    input  logic [WIDTH-1:0] cfg_s,
    output logic             mode,
    output logic [3:0]       mc,
    output logic             div_pulse,
    output logic             div_out,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] P_RST_V  = WIDTH'(P_RST);
    localparam logic [WIDTH-1:0] S_RST_V  = WIDTH'(S_RST);
    localparam logic [WIDTH-1:0] PCNT_RST = WIDTH'(P_RST - 1);
    localparam state_t           ST_RST   = (S_RST != 0) ? SWALLOW : COUNT;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] p_act;
    logic [WIDTH-1:0] s_act;
    logic [WIDTH-1:0] p_cnt;
    logic [WIDTH-1:0] s_cnt;
    logic [WIDTH-1:0] p_cnt_nxt;
    logic [WIDTH-1:0] s_cnt_nxt;
    logic [WIDTH-1:0] p_load;
    logic [WIDTH-1:0] s_load;
    logic             wrap;
    logic             pending;
    logic [WIDTH-1:0] shadow_p;
    logic [WIDTH-1:0] shadow_s;

    pulse_swallow_cfg_reg #(
        .WIDTH (WIDTH)
    ) u_cfg_reg (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_p     (cfg_p),
        .cfg_s     (cfg_s),
        .wrap      (wrap),
        .cfg_ready (cfg_ready),
        .pending   (pending),
        .shadow_p  (shadow_p),
        .shadow_s  (shadow_s),
        .cfg_err   (cfg_err)
    );

    // The last prescaler period of an output period is the one with p_cnt == 0.
    assign wrap = (p_cnt == '0);

    // Settings that take effect at the coming wrap: the shadow if one is waiting.
    always_comb begin
        p_load = p_act;
        s_load = s_act;
        if (pending) begin
            p_load = shadow_p;
            s_load = shadow_s;
        end
    end

    // Counter next values: reload at wrap, otherwise count down (s_cnt floors at 0).
    always_comb begin
        p_cnt_nxt = p_cnt - ONE;
        s_cnt_nxt = (s_cnt != '0) ? (s_cnt - ONE) : s_cnt;
        if (wrap) begin
            p_cnt_nxt = p_load - ONE;
            s_cnt_nxt = s_load;
        end
    end

    // FSM next state: swallow while S periods remain, count the rest.
    always_comb begin
        state_nxt = state;
        case (state)
            SWALLOW: begin
                if (wrap) begin
                    state_nxt = (s_load != '0) ? SWALLOW : COUNT;
                end else if (s_cnt_nxt == '0) begin
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (wrap) begin
                    state_nxt = (s_load != '0) ? SWALLOW : COUNT;
                end
            end
            default: state_nxt = ST_RST;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RST;
        end else begin
            state <= state_nxt;
        end
    end

    // Period counters and active settings; the shadow is adopted only at a wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_act <= P_RST_V;
            s_act <= S_RST_V;
            p_cnt <= PCNT_RST;
            s_cnt <= S_RST_V;
        end else begin
            p_cnt <= p_cnt_nxt;
            s_cnt <= s_cnt_nxt;
            if (wrap && pending) begin
                p_act <= shadow_p;
                s_act <= shadow_s;
            end
        end
    end

    // Registered outputs decoded from next-cycle values so they hold for the
    // whole prescaler period they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode      <= (ST_RST == SWALLOW);
            mc        <= mc_for(ST_RST);
            div_pulse <= 1'b0;
            div_out   <= 1'b0;
        end else begin
            mode      <= (state_nxt == SWALLOW);
            mc        <= mc_for(state_nxt);
            div_pulse <= (p_cnt_nxt == '0);
            if (wrap) begin
                div_out <= !div_out;
            end
        end
    end

endmodule

// File: tb/tb_pulse_swallow_ctrl.sv
// Bench for pulse_swallow_ctrl: directed steps followed by random offers,
// every cycle compared against a period-index model of the controller.
module tb_pulse_swallow_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cfg_valid;
    logic         cfg_ready;
    logic [W-1:0] cfg_p;
    logic [W-1:0] cfg_s;
    logic         mode;
    logic [3:0]   mc;
    logic         div_pulse;
    logic         div_out;
    logic         cfg_err;

    int total = 0;
    int bad   = 0;

    // Reference model: position k within the current output period, active
    // (P, S), waiting shadow, output toggle and sticky error.
    int m_k;
    int m_p;
    int m_s;
    int m_sh_p;
    int m_sh_s;
    bit m_pend;
    bit m_dout;
    bit m_err;

    pulse_swallow_ctrl #(
        .WIDTH (W),
        .P_RST (2),
        .S_RST (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_p     (cfg_p),
        .cfg_s     (cfg_s),
        .mode      (mode),
        .mc        (mc),
        .div_pulse (div_pulse),
        .div_out   (div_out),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int p, input int s);
`ifdef PSWALLOW_CFG_CHECK_EN
        return (p >= 2) && (s <= p);
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_k    = 0;
        m_p    = 2;
        m_s    = 0;
        m_pend = 1'b0;
        m_dout = 1'b0;
        m_err  = 1'b0;
    endtask

    // One prescaler period elapses: advance within the period or wrap.
    task automatic model_edge();
        bit acc;
        acc = cfg_valid && !m_pend;
        if (m_k == m_p - 1) begin
            m_dout = !m_dout;
            m_k    = 0;
            if (m_pend) begin
                m_p    = m_sh_p;
                m_s    = m_sh_s;
                m_pend = 1'b0;
            end
        end else begin
            m_k++;
        end
        if (acc) begin
            if (legal(int'(cfg_p), int'(cfg_s))) begin
                m_pend = 1'b1;
                m_sh_p = int'(cfg_p);
                m_sh_s = int'(cfg_s);
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string where);
        bit exp_mode;
        exp_mode = (m_k < m_s);
        chk({where, ".mode"}, mode, exp_mode);
        chk({where, ".mc"}, mc, exp_mode ? 4'd2 : 4'd1);
        chk({where, ".div_pulse"}, div_pulse, (m_k == m_p - 1));
        chk({where, ".div_out"}, div_out, m_dout);
        chk({where, ".cfg_ready"}, cfg_ready, !m_pend);
        chk({where, ".cfg_err"}, cfg_err, m_err);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("cycle");
    endtask

    // Reset is checked while still asserted, before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_outputs("reset");
        #5;
        reset = 1'b0;
    endtask

    task automatic offer_once(input int p, input int s);
        cfg_p     = W'(p);
        cfg_s     = W'(s);
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Waits for the next div_out edge, then adds up input clocks (3 per /3
    // period, 2 per /2 period) until the following edge.
    task automatic measure_half(input int exp_n, input string tag);
        int   n;
        int   sum;
        logic prev;
        prev = div_out;
        n    = 0;
        while (div_out === prev && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".wrap_seen"}, (n < 40), 1);
        sum  = 0;
        prev = div_out;
        n    = 0;
        while (n < 40) begin
            sum += (mc === 4'd2) ? 3 : 2;
            tick();
            n++;
            if (div_out !== prev) break;
        end
        chk({tag, ".in_clks"}, sum, exp_n);
    endtask

    initial begin
        int waited;
        bit was_ready;
        int rp;
        int rs;

        cfg_valid = 1'b0;
        cfg_p     = '0;
        cfg_s     = '0;
        #1;

        // Reset defaults: P=2, S=0
        do_reset();
        repeat (8) tick();
        measure_half(4, "default");

        // P=5, S=3: 13 input clocks per div_out half-period
        offer_once(5, 3);
        measure_half(13, "p5s3");
        repeat (10) tick();

        // Second offer while the first is still pending
        cfg_p     = W'(4);
        cfg_s     = W'(1);
        cfg_valid = 1'b1;
        tick();
        cfg_p  = W'(6);
        cfg_s  = W'(2);
        waited = 0;
        do begin
            was_ready = cfg_ready;
            tick();
            waited++;
        end while (!was_ready && waited < 40);
        cfg_valid = 1'b0;
        chk("second_offer.accepted", was_ready, 1);
        chk("second_offer.held_off", (waited > 1), 1);
        measure_half(14, "p6s2");

        // S = P: permanently divide-by-3, N = 12
        offer_once(4, 4);
        measure_half(12, "p4s4");
        repeat (12) tick();

`ifdef PSWALLOW_CFG_CHECK_EN
        // Illegal offers are dropped and flagged
        offer_once(3, 4);
        repeat (3) tick();
        chk("bad_s_gt_p.cfg_err", cfg_err, 1);
        measure_half(12, "after_bad_s");
        offer_once(1, 0);
        measure_half(12, "after_bad_p");
`else
        chk("cfg_err_tied", cfg_err, 0);
`endif

        // Reset mid-period with a shadow waiting: it must never be applied
        offer_once(7, 2);
        tick();
        do_reset();
        measure_half(4, "post_reset");
        repeat (20) tick();

        // Random offers against the model
        for (int i = 0; i < 400; i++) begin
            rp = int'($urandom_range(2, 12));
            rs = int'($urandom_range(0, rp));
`ifdef PSWALLOW_CFG_CHECK_EN
            if ($urandom_range(0, 9) == 0) rs = rp + 1;
`endif
            cfg_p     = rp[W-1:0];
            cfg_s     = rs[W-1:0];
            cfg_valid = ($urandom_range(0, 3) == 0);
            tick();
        end
        cfg_valid = 1'b0;

        do_reset();
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
